// File: rtl/soin_bpredictor_resolve.sv
// -----------------------------------------------------------------------------
// soin_bpredictor_resolve
//
// Execute-side end of the branch predictor interface. Each resolved branch is
// compared with the prediction made at fetch. On a mispredict a one-cycle
// fetch redirect and RAS recovery pulse are raised and the 1-bit epoch toggles,
// so that wrong-path resolutions still in flight are discarded when they
// arrive. Every epoch-matching resolution is pushed into a small FIFO, with its
// 2-bit saturating counter in meta already updated. The FIFO drains into the
// predictor's execute_bpredictor_* update port.
//
// Ports
//   clk, reset                        clock (rising edge), async active-low reset
//   execute_resolve_*                 resolved branch in, valid/ready handshake
//   fetch_redirect, _PC               one-cycle redirect pulse and corrected PC
//   resolve_fetch_epoch               current epoch, used to tag fetched branches
//   execute_bpredictor_*              queue head presented to the predictor
//   execute_bpredictor_recover_ras    one-cycle RAS recovery pulse
//   soin_bpredictor_stall             predictor busy, hold the queue head
// -----------------------------------------------------------------------------
module soin_bpredictor_resolve #(
  parameter int QDEPTH_L = 2,
  parameter int META_W   = 18,
  parameter int CTR_LSB  = 12,
  parameter int RAS_LSB  = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              execute_resolve_valid,
  output logic              resolve_execute_ready,
  input  logic              execute_resolve_epoch,
  input  logic [31:0]       execute_resolve_PC,
  input  logic              execute_resolve_dir,
  input  logic [31:0]       execute_resolve_target,
  input  logic              execute_resolve_p_dir,
  input  logic [31:0]       execute_resolve_p_target,
  input  logic [META_W-1:0] execute_resolve_meta,
  output logic              fetch_redirect,
  output logic [31:0]       fetch_redirect_PC,
  output logic              resolve_fetch_epoch,
  output logic              execute_bpredictor_update,
  output logic [31:0]       execute_bpredictor_PC,
  output logic [31:0]       execute_bpredictor_target,
  output logic              execute_bpredictor_dir,
  output logic              execute_bpredictor_miss,
  output logic [META_W-1:0] execute_bpredictor_meta,
  output logic              execute_bpredictor_recover_ras,
  input  logic              soin_bpredictor_stall
);

  localparam int DEPTH = 1 << QDEPTH_L;
  localparam logic [QDEPTH_L:0] DEPTH_C = (QDEPTH_L + 1)'(DEPTH);

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       target;
    logic              dir;
    logic              miss;
    logic [META_W-1:0] meta;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  entry_t                mem_q [DEPTH];
  logic [QDEPTH_L-1:0]   wr_ptr_q, wr_ptr_d;
  logic [QDEPTH_L-1:0]   rd_ptr_q, rd_ptr_d;
  logic [QDEPTH_L:0]     count_q,  count_d;
  logic                  epoch_q,  epoch_d;
  logic                  redirect_q, redirect_d;
  logic [31:0]           redirect_pc_q, redirect_pc_d;
  logic [META_W-1:0]     bypass_meta_q, bypass_meta_d;

  // ---------------------------------------------------------------------------
  // Resolve evaluation
  // ---------------------------------------------------------------------------
  logic              queue_full;
  logic              head_valid;
  logic              accept;
  logic              push;
  logic              pop;
  logic              res_miss;
  logic              do_redirect;
  logic [31:0]       next_pc;
  logic [1:0]        ctr;
  logic [1:0]        ctr_nxt;
  logic [META_W-1:0] upd_meta;
  entry_t            new_entry;
  entry_t            head;

  assign queue_full            = (count_q == DEPTH_C);
  assign head_valid            = (count_q != '0);
  assign resolve_execute_ready = !queue_full;
  assign accept                = execute_resolve_valid & resolve_execute_ready;
  // Resolutions tagged with a stale epoch are wrong-path and vanish here.
  assign push                  = accept & (execute_resolve_epoch == epoch_q);

  // A not-taken branch's target is irrelevant, so only compare it when taken.
  assign res_miss = (execute_resolve_p_dir != execute_resolve_dir) |
                    (execute_resolve_dir & (execute_resolve_p_target != execute_resolve_target));
  assign do_redirect = push & res_miss;
  assign next_pc     = execute_resolve_dir ? execute_resolve_target
                                           : execute_resolve_PC + 32'd4;

  // NOTE: every variable assigned in an always_comb gets a value on every path
  // (here by a default first), otherwise synthesis infers a latch.
  always_comb begin
    ctr      = execute_resolve_meta[CTR_LSB +: 2];
    ctr_nxt  = ctr;
    if (execute_resolve_dir) begin
      if (ctr != 2'd3) ctr_nxt = ctr + 2'd1;
    end else begin
      if (ctr != 2'd0) ctr_nxt = ctr - 2'd1;
    end
    upd_meta = execute_resolve_meta;
    upd_meta[CTR_LSB +: 2] = ctr_nxt;
  end

  always_comb begin
    new_entry.pc     = execute_resolve_PC;
    new_entry.target = execute_resolve_target;
    new_entry.dir    = execute_resolve_dir;
    new_entry.miss   = res_miss;
    new_entry.meta   = upd_meta;
  end

  // ---------------------------------------------------------------------------
  // Queue pointers, epoch and redirect next-state
  // ---------------------------------------------------------------------------
  // The RAS-recovery cycle owns the meta bus, so no update may pop in it.
  assign pop = head_valid & !soin_bpredictor_stall & !redirect_q;

  always_comb begin
    wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d      = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d       = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
    epoch_d       = do_redirect ? ~epoch_q : epoch_q;
    redirect_d    = do_redirect;
    redirect_pc_d = do_redirect ? next_pc : redirect_pc_q;
    bypass_meta_d = do_redirect ? upd_meta : bypass_meta_q;
    // The RAS index handed to recovery always comes from the fetch-time meta,
    // even if a different counter placement ever overlaps that field.
    if (do_redirect) bypass_meta_d[RAS_LSB +: 4] = execute_resolve_meta[RAS_LSB +: 4];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      epoch_q       <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      bypass_meta_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      epoch_q       <= epoch_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      bypass_meta_q <= bypass_meta_d;
    end
  end

  // NOTE: the queue storage has no reset; emptiness lives in count_q, and the
  // outputs below are gated by head_valid so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign head = head_valid ? mem_q[rd_ptr_q] : '0;

  assign fetch_redirect                 = redirect_q;
  assign fetch_redirect_PC              = redirect_pc_q;
  assign resolve_fetch_epoch            = epoch_q;
  assign execute_bpredictor_recover_ras = redirect_q;
  assign execute_bpredictor_update      = pop;
  assign execute_bpredictor_PC          = head.pc;
  assign execute_bpredictor_target      = head.target;
  assign execute_bpredictor_dir         = head.dir;
  assign execute_bpredictor_miss        = head.miss;
  assign execute_bpredictor_meta        = redirect_q ? bypass_meta_q : head.meta;

endmodule

// File: tb/tb_soin_bpredictor_resolve.sv
// -----------------------------------------------------------------------------
// tb_soin_bpredictor_resolve
//
// Directed bench for soin_bpredictor_resolve: a table of single-branch
// resolutions with hand-computed expectations, followed by hand-written
// sequences for queue-full under stall and reset asserted mid-stream.
// -----------------------------------------------------------------------------
module tb_soin_bpredictor_resolve;

  logic        clk;
  logic        reset;
  logic        valid;
  logic        ready;
  logic        r_epoch;
  logic [31:0] r_pc;
  logic        r_dir;
  logic [31:0] r_target;
  logic        r_p_dir;
  logic [31:0] r_p_target;
  logic [17:0] r_meta;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        f_epoch;
  logic        upd;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_dir;
  logic        upd_miss;
  logic [17:0] upd_meta;
  logic        recover_ras;
  logic        stall;

  int n_cmp = 0;
  int n_bad = 0;
  logic tb_epoch = 1'b0;

  soin_bpredictor_resolve dut (
    .clk                            (clk),
    .reset                          (reset),
    .execute_resolve_valid          (valid),
    .resolve_execute_ready          (ready),
    .execute_resolve_epoch          (r_epoch),
    .execute_resolve_PC             (r_pc),
    .execute_resolve_dir            (r_dir),
    .execute_resolve_target         (r_target),
    .execute_resolve_p_dir          (r_p_dir),
    .execute_resolve_p_target       (r_p_target),
    .execute_resolve_meta           (r_meta),
    .fetch_redirect                 (redirect),
    .fetch_redirect_PC              (redirect_pc),
    .resolve_fetch_epoch            (f_epoch),
    .execute_bpredictor_update      (upd),
    .execute_bpredictor_PC          (upd_pc),
    .execute_bpredictor_target      (upd_target),
    .execute_bpredictor_dir         (upd_dir),
    .execute_bpredictor_miss        (upd_miss),
    .execute_bpredictor_meta        (upd_meta),
    .execute_bpredictor_recover_ras (recover_ras),
    .soin_bpredictor_stall          (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        stale;
    logic [31:0] pc;
    logic        dir;
    logic [31:0] tgt;
    logic        p_dir;
    logic [31:0] p_tgt;
    logic [17:0] meta;
    logic        exp_miss;
    logic [31:0] exp_npc;
    logic [17:0] exp_meta;
  } vec_t;

  function automatic vec_t mk(input logic stale, input logic [31:0] pc, input logic dir,
                              input logic [31:0] tgt, input logic p_dir, input logic [31:0] p_tgt,
                              input logic [17:0] meta, input logic exp_miss,
                              input logic [31:0] exp_npc, input logic [17:0] exp_meta);
    vec_t v;
    v.stale = stale; v.pc = pc; v.dir = dir; v.tgt = tgt; v.p_dir = p_dir; v.p_tgt = p_tgt;
    v.meta = meta; v.exp_miss = exp_miss; v.exp_npc = exp_npc; v.exp_meta = exp_meta;
    return v;
  endfunction

  task automatic drive(input logic ep, input logic [31:0] pc, input logic dir, input logic [31:0] tgt,
                       input logic p_dir, input logic [31:0] p_tgt, input logic [17:0] meta);
    valid = 1'b1; r_epoch = ep; r_pc = pc; r_dir = dir; r_target = tgt;
    r_p_dir = p_dir; r_p_target = p_tgt; r_meta = meta;
  endtask

  vec_t vecs[8];

  initial begin
    // meta layout: [17:14] RAS index, [13:12] counter, [11:0] other
    vecs[0] = mk(0, 32'h100, 1, 32'h200, 1, 32'h200, 18'h02000, 0, 32'h200, 18'h03000); // T2 hit, ctr 2->3
    vecs[1] = mk(0, 32'h100, 0, 32'h300, 1, 32'h300, 18'h285A5, 1, 32'h104, 18'h285A5); // T3 miss, ctr stays 0
    vecs[2] = mk(1, 32'h400, 0, 32'h500, 1, 32'h500, 18'h01000, 1, 32'h404, 18'h00000); // T4 stale, dropped
    vecs[3] = mk(0, 32'h500, 1, 32'h600, 1, 32'h604, 18'h03FFF, 1, 32'h600, 18'h03FFF); // target miss, ctr sat at 3
    vecs[4] = mk(0, 32'h700, 0, 32'h800, 0, 32'h704, 18'h3D000, 0, 32'h704, 18'h3C000); // NT hit, ctr 1->0
    vecs[5] = mk(0, 32'hFFFFFFFC, 0, 32'h10, 1, 32'h10, 18'h02000, 1, 32'h0, 18'h01000); // T6 wrap
    vecs[6] = mk(0, 32'h900, 1, 32'hA00, 0, 32'h904, 18'h01000, 1, 32'hA00, 18'h02000); // pred NT, taken
    vecs[7] = mk(0, 32'hB00, 0, 32'hC00, 0, 32'h1234, 18'h00000, 0, 32'hB04, 18'h00000); // NT, target ignored

    reset = 1'b0; valid = 1'b0; stall = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0); valid = 1'b0;
    #2;
    check("reset_ready", ready, 1);
    check("reset_redirect", redirect, 0);
    check("reset_update", upd, 0);
    check("reset_recover", recover_ras, 0);
    check("reset_epoch", f_epoch, 0);
    check("reset_meta", upd_meta, 0);
    @(negedge clk); reset = 1'b1;

    // ---------------- table-driven single resolutions ----------------
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(vecs[i].stale ? ~tb_epoch : tb_epoch, vecs[i].pc, vecs[i].dir, vecs[i].tgt,
            vecs[i].p_dir, vecs[i].p_tgt, vecs[i].meta);
      @(posedge clk); #1;
      valid = 1'b0;
      check($sformatf("v%0d_redirect", i), redirect, !vecs[i].stale && vecs[i].exp_miss);
      check($sformatf("v%0d_recover", i), recover_ras, !vecs[i].stale && vecs[i].exp_miss);
      if (!vecs[i].stale && vecs[i].exp_miss) begin
        tb_epoch = ~tb_epoch;
        check($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].exp_npc);
        check($sformatf("v%0d_bypass_meta", i), upd_meta, vecs[i].exp_meta);
        check($sformatf("v%0d_update_blocked", i), upd, 0);
        @(posedge clk); #1;
        check($sformatf("v%0d_redirect_gone", i), redirect, 0);
      end
      check($sformatf("v%0d_epoch", i), f_epoch, tb_epoch);
      check($sformatf("v%0d_update", i), upd, !vecs[i].stale);
      if (!vecs[i].stale) begin
        check($sformatf("v%0d_pc", i), upd_pc, vecs[i].pc);
        check($sformatf("v%0d_target", i), upd_target, vecs[i].tgt);
        check($sformatf("v%0d_dir", i), upd_dir, vecs[i].dir);
        check($sformatf("v%0d_miss", i), upd_miss, vecs[i].exp_miss);
        check($sformatf("v%0d_meta", i), upd_meta, vecs[i].exp_meta);
      end
    end
    @(posedge clk); #1;
    check("drained_update", upd, 0);

    // ---------------- T5: fill under stall, then drain ----------------
    @(negedge clk); stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(tb_epoch, 32'h1000 + 32'(16 * i), 1, 32'h2000, 1, 32'h2000, 18'h02000);
      #1;
      check($sformatf("fill%0d_ready", i), ready, i < 4);
      @(negedge clk);
    end
    valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d_update", i), upd, 0);
      check($sformatf("stall%0d_head", i), upd_pc, 32'h1000);
      check($sformatf("stall%0d_ready", i), ready, 0);
      @(negedge clk);
    end
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("drain%0d_update", i), upd, 1);
      check($sformatf("drain%0d_pc", i), upd_pc, 32'h1000 + 32'(16 * i));
      check($sformatf("drain%0d_meta", i), upd_meta, 18'h03000);
      @(negedge clk);
      check($sformatf("drain%0d_ready", i), ready, 1);
    end
    check("drain_done", upd, 0);

    // ---------------- T1: async reset mid-stream ----------------
    stall = 1'b1;
    drive(tb_epoch, 32'h1100, 1, 32'h1180, 1, 32'h1180, 18'h02000);
    @(negedge clk);
    drive(tb_epoch, 32'h1200, 0, 32'h1280, 1, 32'h1280, 18'h02000);
    @(posedge clk); #1;
    valid = 1'b0;
    check("pre_reset_redirect", redirect, 1);
    #2 reset = 1'b0;
    #1;
    check("async_update", upd, 0);
    check("async_redirect", redirect, 0);
    check("async_recover", recover_ras, 0);
    check("async_ready", ready, 1);
    check("async_epoch", f_epoch, 0);
    check("async_pc", upd_pc, 0);
    @(negedge clk); reset = 1'b1; stall = 1'b0;
    @(posedge clk); #1;
    check("post_reset_empty", upd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
